block_game_sequencer: RTL and testbench
=======================================

Name: block_game_sequencer

Overview:
- Sequences the movable block's datapath. Arbitrates the four direction buttons and issues paced single-step move commands.
- Checks the block centre against the red hazard zone and the goal zone once per frame, and tracks lives.
- Runs the IDLE/PLAY/HIT/WIN/OVER game state machine. Sits between button debouncers and the block position/draw logic; the position logic consumes step and respawn commands.

Parameters:
- STEP_DIV, 2, frame ticks between consecutive steps while a direction is held (1..15).
- HIT_FRAMES, 60, frames the block stays frozen after a hazard hit.
- LIVES_INIT, 3, lives loaded on reset and on start from IDLE/WIN/OVER (1..3).
- RED_X0/RED_X1/RED_Y0/RED_Y1, 417/527/300/475, hazard rectangle, inclusive.
- GOAL_X0/GOAL_X1/GOAL_Y0/GOAL_Y1, 528/784/476/515, goal rectangle, inclusive.
- HALF, 5, block half-size used for overlap tests.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-low reset.
- frame_tick  in  1  one-cycle pulse per video frame.
- start  in  1  level; start/restart request.
- up, down, left, right  in  1 each  debounced level buttons.
- xpos, ypos  in  10 each  current block centre.
- step_vld  out  1  one-cycle step command.
- step_dir  out  2  00 right, 01 left, 10 up, 11 down; valid with step_vld.
- respawn  out  1  one-cycle pulse: position logic reloads its start point.
- freeze  out  1  high when moves are blocked.
- state  out  3  IDLE=0, PLAY=1, HIT=2, WIN=3, OVER=4.
- lives  out  2  remaining lives.

Behaviour:
- Reset (rst==0 at posedge clk):
  - state=IDLE, lives=LIVES_INIT, step_vld=0, step_dir=00, respawn=0, freeze=1.
  - Pace and hit counters are cleared.
- Reset asserted mid-operation wins over every other event in the same cycle.
- Arbitration: fixed priority right > left > up > down. Only the winner is considered each cycle.
- Pacing (PLAY only):
  - Pace counter cp counts frame_tick while any direction is held; cp=0 whenever no direction is held.
  - On the frame_tick where a direction is held and cp==0: step_vld=1 with the winning step_dir, and cp loads STEP_DIV-1.
  - Each later frame_tick decrements cp. The first press therefore steps on the next frame_tick.
  - step_vld is registered and asserts 1 cycle after that frame_tick.
- Collision (PLAY, evaluated on frame_tick):
  - Overlap means xpos+HALF>=X0, xpos-HALF<=X1, ypos+HALF>=Y0 and ypos-HALF<=Y1.
  - Arithmetic is 11-bit unsigned. xpos-HALF underflow is treated as 0.
  - If hazard and goal both overlap on the same tick, hazard wins.
  - A step issued on the same tick is still emitted.
- State transitions:
  - IDLE: freeze=1. start=1 -> PLAY, lives=LIVES_INIT, respawn pulse.
  - PLAY: freeze=0. Hazard overlap -> HIT, lives decremented, hit counter=HIT_FRAMES. Goal overlap -> WIN.
  - HIT: freeze=1, no steps, the hit counter decrements per frame_tick. At 0: if lives==0 -> OVER; else -> PLAY with a respawn pulse.
  - WIN and OVER: freeze=1, held until start is seen low then high (edge-detected); then -> PLAY, lives reloaded, respawn pulse.
  - start held continuously from IDLE gives only one transition.
- Output rules:
  - respawn is exactly one cycle wide and coincident with entry into PLAY.
  - lives never underflows below 0.
  - Buttons are ignored outside PLAY; cp is cleared on leaving PLAY.

Optional Feature:
- Macro BLOCK_GAME_ACCEL_EN.
- Defined: after 8 consecutive steps in the same direction without release or direction change, the step interval drops to 1 frame_tick. Release or a direction change restores STEP_DIV.
- Undefined: the interval is always STEP_DIV. The accel step counter is absent.

Test Plan:
- Reset then start: hold rst=0 for 2 cycles, then start=1 -> state 0->1, one respawn pulse, lives=3, freeze=0.
- Pacing: STEP_DIV=2, hold right for 6 frame_ticks -> step_vld on ticks 1, 3, 5 with step_dir=00; up held too -> still 00.
- Hazard: xpos=420, ypos=350 on frame_tick -> state=HIT, lives=2, freeze=1; after 60 ticks -> PLAY with respawn; repeat to lives=0 -> OVER.
- Goal and overlap: xpos=600, ypos=490 -> WIN. Set xpos=525, ypos=476 so both overlap -> HIT (hazard priority).
- Restart: in OVER, start held high gives no change; low then high -> PLAY, lives=3, respawn.
- Accel (macro defined): hold left for 12 steps with STEP_DIV=2 -> intervals 2,2,...(8 steps) then 1; release -> interval back to 2.

Source files
------------

// File: rtl/block_game_sequencer_if.sv
// Control/status bundle between the game sequencer and its neighbours (debouncers, position logic,
// frame timing). master drives the inputs of the sequencer; slave is the sequencer itself.
interface block_game_sequencer_if;
    logic       frame_tick;
    logic       start;
    logic       up;
    logic       down;
    logic       left;
    logic       right;
    logic [9:0] xpos;
    logic [9:0] ypos;
    logic       step_vld;
    logic [1:0] step_dir;
    logic       respawn;
    logic       freeze;
    logic [2:0] state;
    logic [1:0] lives;

    modport master (
        output frame_tick, start, up, down, left, right, xpos, ypos,
        input  step_vld, step_dir, respawn, freeze, state, lives
    );

    modport slave (
        input  frame_tick, start, up, down, left, right, xpos, ypos,
        output step_vld, step_dir, respawn, freeze, state, lives
    );
endinterface

// File: rtl/block_game_sequencer.sv
// Game sequencer: button arbitration, paced step commands, per-frame hazard/goal checks, lives.
// Optional BLOCK_GAME_ACCEL_EN: after 8 same-direction steps the step interval drops to 1 tick.
module block_game_sequencer #(
    parameter int unsigned STEP_DIV   = 2,
    parameter int unsigned HIT_FRAMES = 60,
    parameter int unsigned LIVES_INIT = 3,
    parameter int unsigned RED_X0     = 417,
    parameter int unsigned RED_X1     = 527,
    parameter int unsigned RED_Y0     = 300,
    parameter int unsigned RED_Y1     = 475,
    parameter int unsigned GOAL_X0    = 528,
    parameter int unsigned GOAL_X1    = 784,
    parameter int unsigned GOAL_Y0    = 476,
    parameter int unsigned GOAL_Y1    = 515,
    parameter int unsigned HALF       = 5
) (
    input logic                  clk,
    input logic                  rst,
    block_game_sequencer_if.slave bus
);

    localparam int unsigned HitW      = $clog2(HIT_FRAMES + 1);
    localparam logic [HitW-1:0] HitInit = HitW'(HIT_FRAMES);
    localparam logic [3:0]  StepLoad  = 4'(STEP_DIV - 1);
    localparam logic [1:0]  LivesLoad = 2'(LIVES_INIT);

    typedef enum logic [2:0] {
        StIdle = 3'd0,
        StPlay = 3'd1,
        StHit  = 3'd2,
        StWin  = 3'd3,
        StOver = 3'd4
    } state_e;

    state_e          state_q, state_d;
    logic [1:0]      lives_q, lives_d;
    logic [3:0]      cp_q, cp_d;
    logic [HitW-1:0] hit_q, hit_d;
    logic            step_vld_q, step_vld_d;
    logic [1:0]      step_dir_q, step_dir_d;
    logic            respawn_q, respawn_d;
    logic            start_q;

    logic       any_held;
    logic [1:0] win_dir;
    logic [3:0] step_load;
    logic       hazard, goal, start_rise;

    // Centre +/- HALF against an inclusive box; the low side clamps at 0 instead of wrapping.
    function automatic logic overlap(input logic [9:0] x, input logic [9:0] y,
                                     input logic [10:0] x0, input logic [10:0] x1,
                                     input logic [10:0] y0, input logic [10:0] y1);
        logic [10:0] xh, xl, yh, yl;
        xh = {1'b0, x} + 11'(HALF);
        yh = {1'b0, y} + 11'(HALF);
        xl = ({1'b0, x} >= 11'(HALF)) ? {1'b0, x} - 11'(HALF) : 11'd0;
        yl = ({1'b0, y} >= 11'(HALF)) ? {1'b0, y} - 11'(HALF) : 11'd0;
        return (xh >= x0) && (xl <= x1) && (yh >= y0) && (yl <= y1);
    endfunction

    always_comb begin
        any_held = bus.right | bus.left | bus.up | bus.down;
        if (bus.right)     win_dir = 2'b00;
        else if (bus.left) win_dir = 2'b01;
        else if (bus.up)   win_dir = 2'b10;
        else               win_dir = 2'b11;
        hazard = overlap(bus.xpos, bus.ypos, 11'(RED_X0), 11'(RED_X1), 11'(RED_Y0), 11'(RED_Y1));
        goal   = overlap(bus.xpos, bus.ypos, 11'(GOAL_X0), 11'(GOAL_X1), 11'(GOAL_Y0),
                         11'(GOAL_Y1));
        start_rise = bus.start & ~start_q;
    end

`ifdef BLOCK_GAME_ACCEL_EN
    localparam logic [3:0] AccelSteps = 4'd8;
    logic [3:0] acc_q, acc_d, acc_base, acc_step;

    // Run length of same-direction steps, saturating at AccelSteps.
    always_comb begin
        acc_base  = (any_held && win_dir == step_dir_q) ? acc_q : 4'd0;
        acc_step  = (acc_base >= AccelSteps) ? acc_base : acc_base + 4'd1;
        step_load = (acc_step >= AccelSteps) ? 4'd0 : StepLoad;
    end

    always_comb begin
        acc_d = acc_base;
        if (state_q != StPlay || state_d != StPlay) acc_d = 4'd0;
        else if (step_vld_d)                        acc_d = acc_step;
    end

    always_ff @(posedge clk) begin
        if (!rst) acc_q <= 4'd0;
        else      acc_q <= acc_d;
    end
`else
    assign step_load = StepLoad;
`endif

    always_comb begin
        state_d    = state_q;
        lives_d    = lives_q;
        cp_d       = cp_q;
        hit_d      = hit_q;
        step_vld_d = 1'b0;
        step_dir_d = step_dir_q;
        case (state_q)
            StIdle: begin
                if (bus.start) begin
                    state_d = StPlay;
                    lives_d = LivesLoad;
                end
            end
            StPlay: begin
                if (!any_held) begin
                    cp_d = 4'd0;
                end else if (bus.frame_tick) begin
                    if (cp_q == 4'd0) begin
                        step_vld_d = 1'b1;
                        step_dir_d = win_dir;
                        cp_d       = step_load;
                    end else begin
                        cp_d = cp_q - 4'd1;
                    end
                end
                if (bus.frame_tick) begin
                    if (hazard) begin
                        state_d = StHit;
                        lives_d = (lives_q == 2'd0) ? 2'd0 : lives_q - 2'd1;
                        hit_d   = HitInit;
                    end else if (goal) begin
                        state_d = StWin;
                    end
                end
                if (state_d != StPlay) cp_d = 4'd0;
            end
            StHit: begin
                if (hit_q == '0) begin
                    state_d = (lives_q == 2'd0) ? StOver : StPlay;
                end else if (bus.frame_tick) begin
                    hit_d = hit_q - 1'b1;
                end
            end
            StWin, StOver: begin
                if (start_rise) begin
                    state_d = StPlay;
                    lives_d = LivesLoad;
                end
            end
            default: state_d = StIdle;
        endcase
        respawn_d = (state_d == StPlay) && (state_q != StPlay);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= StIdle;
            lives_q    <= LivesLoad;
            cp_q       <= 4'd0;
            hit_q      <= '0;
            step_vld_q <= 1'b0;
            step_dir_q <= 2'b00;
            respawn_q  <= 1'b0;
            start_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            lives_q    <= lives_d;
            cp_q       <= cp_d;
            hit_q      <= hit_d;
            step_vld_q <= step_vld_d;
            step_dir_q <= step_dir_d;
            respawn_q  <= respawn_d;
            start_q    <= bus.start;
        end
    end

    assign bus.step_vld = step_vld_q;
    assign bus.step_dir = step_dir_q;
    assign bus.respawn  = respawn_q;
    assign bus.freeze   = (state_q != StPlay);
    assign bus.state    = state_q;
    assign bus.lives    = lives_q;

endmodule

// File: tb/tb_block_game_sequencer.sv
// Randomized bench for block_game_sequencer against a frame-level behavioural model of the game.
module tb_block_game_sequencer;

    localparam int STEP_DIV   = 2;
    localparam int HIT_FRAMES = 60;
    localparam int LIVES_INIT = 3;
    localparam int HALF       = 5;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    block_game_sequencer_if bus ();

    block_game_sequencer #(
        .STEP_DIV  (STEP_DIV),
        .HIT_FRAMES(HIT_FRAMES),
        .LIVES_INIT(LIVES_INIT),
        .HALF      (HALF)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int errors = 0;
    int checks = 0;

    task automatic check_eq(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: game state as plain integers; pacing as "frames held so far modulo STEP_DIV".
    int m_state, m_lives, m_held_frames, m_hit_frames, m_step_dir;
    bit m_step, m_respawn, m_prev_start, m_just_reset;

    function automatic bit in_box(int x, int y, int x0, int x1, int y0, int y1);
        int xl = (x >= HALF) ? x - HALF : 0;
        int yl = (y >= HALF) ? y - HALF : 0;
        return (x + HALF >= x0) && (xl <= x1) && (y + HALF >= y0) && (yl <= y1);
    endfunction

    task automatic model_edge();
        int  nxt;
        bit  held;
        int  dir;
        m_just_reset = 1'b0;
        if (!rst) begin
            m_state = 0; m_lives = LIVES_INIT; m_held_frames = 0; m_hit_frames = 0;
            m_step = 0; m_step_dir = 0; m_respawn = 0; m_prev_start = 0; m_just_reset = 1'b1;
            return;
        end
        held = bus.right | bus.left | bus.up | bus.down;
        dir  = bus.right ? 0 : bus.left ? 1 : bus.up ? 2 : 3;
        nxt  = m_state;
        m_step = 0;
        case (m_state)
            0: if (bus.start) begin nxt = 1; m_lives = LIVES_INIT; end
            1: begin
                if (!held) m_held_frames = 0;
                else if (bus.frame_tick) begin
                    if (m_held_frames % STEP_DIV == 0) begin m_step = 1; m_step_dir = dir; end
                    m_held_frames++;
                end
                if (bus.frame_tick) begin
                    if (in_box(bus.xpos, bus.ypos, 417, 527, 300, 475)) begin
                        nxt = 2; m_hit_frames = 0;
                        m_lives = (m_lives > 0) ? m_lives - 1 : 0;
                    end else if (in_box(bus.xpos, bus.ypos, 528, 784, 476, 515)) nxt = 3;
                end
            end
            2: begin
                if (m_hit_frames == HIT_FRAMES) nxt = (m_lives == 0) ? 4 : 1;
                else if (bus.frame_tick) m_hit_frames++;
            end
            default: if (bus.start && !m_prev_start) begin nxt = 1; m_lives = LIVES_INIT; end
        endcase
        if (nxt != 1) m_held_frames = 0;
        m_respawn    = (nxt == 1) && (m_state != 1);
        m_prev_start = bus.start;
        m_state      = nxt;
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        check_eq("state", int'(bus.state), m_state);
        check_eq("lives", int'(bus.lives), m_lives);
        check_eq("freeze", int'(bus.freeze), (m_state != 1) ? 1 : 0);
        check_eq("respawn", int'(bus.respawn), int'(m_respawn));
        check_eq("step_vld", int'(bus.step_vld), int'(m_step));
        if (m_step || m_just_reset) check_eq("step_dir", int'(bus.step_dir), m_step_dir);
    endtask

    task automatic set_btn(input logic [3:0] rlud);
        {bus.right, bus.left, bus.up, bus.down} = rlud;
    endtask

    task automatic tick_frames(input int n);
        for (int i = 0; i < n; i++) begin
            bus.frame_tick = 1'b1;
            cycle();
            bus.frame_tick = 1'b0;
            cycle();
            cycle();
        end
    endtask

    initial begin
        bus.frame_tick = 1'b0;
        bus.start      = 1'b0;
        set_btn(4'b0000);
        bus.xpos = 10'd100;
        bus.ypos = 10'd100;

        // Reset, then start from IDLE held for several cycles.
        repeat (2) cycle();
        rst = 1'b1;
        bus.start = 1'b1;
        repeat (4) cycle();
        bus.start = 1'b0;

        // Pacing with right and up held together.
        set_btn(4'b1010);
        tick_frames(6);
        set_btn(4'b0000);

        // Three hazard hits lead to OVER; the last one uses the hazard/goal overlap point.
        for (int h = 0; h < 3; h++) begin
            bus.xpos = (h == 2) ? 10'd525 : 10'd420;
            bus.ypos = (h == 2) ? 10'd476 : 10'd350;
            tick_frames(1);
            bus.xpos = 10'd100;
            bus.ypos = 10'd100;
            tick_frames(HIT_FRAMES + 1);
        end

        // Restart needs a fresh rising edge of start.
        bus.start = 1'b1;
        repeat (3) cycle();
        bus.start = 1'b0;
        cycle();
        bus.start = 1'b1;
        repeat (2) cycle();
        bus.start = 1'b0;

        // Goal.
        bus.xpos = 10'd600;
        bus.ypos = 10'd490;
        tick_frames(1);
        bus.xpos = 10'd100;
        bus.ypos = 10'd100;

        // Randomized play.
        for (int c = 0; c < 6000; c++) begin
            bus.frame_tick = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 7) == 0) set_btn(4'($urandom));
            if ($urandom_range(0, 29) == 0) bus.start = ~bus.start;
            if ($urandom_range(0, 19) == 0) begin
                case ($urandom_range(0, 9))
                    0: begin
                        bus.xpos = 10'($urandom_range(420, 520));
                        bus.ypos = 10'($urandom_range(300, 470));
                    end
                    1: begin
                        bus.xpos = 10'($urandom_range(540, 780));
                        bus.ypos = 10'($urandom_range(480, 510));
                    end
                    2: begin
                        bus.xpos = 10'($urandom_range(520, 535));
                        bus.ypos = 10'($urandom_range(468, 484));
                    end
                    3: begin
                        bus.xpos = 10'($urandom_range(405, 800));
                        bus.ypos = 10'($urandom_range(288, 525));
                    end
                    4: begin
                        bus.xpos = 10'($urandom_range(0, 8));
                        bus.ypos = 10'($urandom_range(0, 8));
                    end
                    default: begin
                        bus.xpos = 10'($urandom_range(0, 400));
                        bus.ypos = 10'($urandom_range(0, 1023));
                    end
                endcase
            end
            rst = ($urandom_range(0, 1499) != 0);
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
